issue_scoreboard_n: RTL

// - Parametrised in-order issue scoreboard for the dispatch stage, between the instruction buffer and the EXE ports.
// - Tracks outstanding writes per architectural register with saturating counters.
// - Each cycle returns the longest issuable in-order prefix of up to ISSUE_WIDTH decoded instructions.
// - Checks RAW hazards against in-flight producers and within the issue group; honours single-issue instructions.

---
 rtl/issue_scoreboard_n.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/issue_scoreboard_n.sv
// issue_scoreboard_n: in-order issue scoreboard for the dispatch stage.
// Tracks outstanding writes per architectural register with saturating
// counters and grants the longest hazard-free in-order prefix of the
// presented issue group.
// Optional feature: SCOREBOARD_RELEASE_BYPASS_EN lets a release in the
// current cycle free a register (cnt==1) for the issue logic at once.
module issue_scoreboard_n #(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            stall,
    input  logic [ISSUE_WIDTH-1:0]          in_valid,
    input  logic [ISSUE_WIDTH*2-1:0]        in_rs_valid,
    input  logic [ISSUE_WIDTH*2*ADDR_W-1:0] in_rs_addr,
    input  logic [ISSUE_WIDTH-1:0]          in_rd_valid,
    input  logic [ISSUE_WIDTH*ADDR_W-1:0]   in_rd_addr,
    input  logic [ISSUE_WIDTH-1:0]          in_single,
    input  logic [ISSUE_WIDTH-1:0]          rel_valid,
    input  logic [ISSUE_WIDTH*ADDR_W-1:0]   rel_addr,
    output logic [ISSUE_WIDTH-1:0]          issue_o,
    output logic [NUM_REGS-1:0]             busy_o,
    output logic                            err_o
);

    // Wide enough to hold a full counter plus one increment per lane.
    localparam int             SW      = CNT_W + 3;
    localparam logic [SW-1:0]  CNT_MAX = SW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]       r_cnt [NUM_REGS];
    logic                   r_err;

    logic [NUM_REGS-1:0]    w_busy_eff;
    logic [ISSUE_WIDTH-1:0] w_issue;
    logic                   w_prev;
    logic                   w_ok;
    logic [ADDR_W-1:0]      w_src;
    logic [ADDR_W-1:0]      w_rd;
    logic [SW-1:0]          w_n;

    logic [CNT_W-1:0]       w_cnt_nxt [NUM_REGS];
    logic                   w_err_set;
    logic [SW-1:0]          w_inc;
    logic [SW-1:0]          w_rel;
    logic [SW-1:0]          w_sum;
    logic [SW-1:0]          w_new;

    // Busy view used by the issue logic, optionally bypassing same-cycle releases.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_busy_eff[r] = (r != 0) && (r_cnt[r] != '0);
`ifdef SCOREBOARD_RELEASE_BYPASS_EN
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (rel_valid[l] && (rel_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(r)) &&
                    (r_cnt[r] == CNT_W'(1)))
                    w_busy_eff[r] = 1'b0;
            end
`endif
        end
    end

    // Grant the longest in-order prefix free of RAW, single-issue and saturation hazards.
    always_comb begin
        w_issue = '0;
        w_prev  = ~stall & ~flush;
        w_ok    = 1'b0;
        w_src   = '0;
        w_rd    = '0;
        w_n     = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            w_ok = w_prev & in_valid[i];
            for (int k = 0; k < 2; k++) begin
                w_src = in_rs_addr[(2*i+k)*ADDR_W +: ADDR_W];
                if (in_rs_valid[2*i+k] && (w_src != '0)) begin
                    if (w_busy_eff[w_src])
                        w_ok = 1'b0;
                    for (int j = 0; j < ISSUE_WIDTH; j++) begin
                        if ((j < i) && w_issue[j] && in_rd_valid[j] &&
                            (in_rd_addr[j*ADDR_W +: ADDR_W] == w_src))
                            w_ok = 1'b0;
                    end
                end
            end
            if ((i > 0) && (in_single[i] || in_single[0]))
                w_ok = 1'b0;
            w_rd = in_rd_addr[i*ADDR_W +: ADDR_W];
            if (in_rd_valid[i] && (w_rd != '0)) begin
                w_n = SW'(r_cnt[w_rd]);
                for (int j = 0; j < ISSUE_WIDTH; j++) begin
                    if ((j < i) && w_issue[j] && in_rd_valid[j] &&
                        (in_rd_addr[j*ADDR_W +: ADDR_W] == w_rd))
                        w_n = w_n + SW'(1);
                end
                if (w_n >= CNT_MAX)
                    w_ok = 1'b0;
            end
            w_issue[i] = w_ok;
            w_prev     = w_ok;
        end
    end

    // Next counter values: grants add, releases subtract, underflow is dropped and flagged.
    always_comb begin
        w_err_set = 1'b0;
        w_inc     = '0;
        w_rel     = '0;
        w_sum     = '0;
        w_new     = '0;
        w_cnt_nxt[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_inc = '0;
            w_rel = '0;
            for (int l = 0; l < ISSUE_WIDTH; l++) begin
                if (w_issue[l] && in_rd_valid[l] && (in_rd_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(r)))
                    w_inc = w_inc + SW'(1);
                if (rel_valid[l] && (rel_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(r)))
                    w_rel = w_rel + SW'(1);
            end
            w_sum = SW'(r_cnt[r]) + w_inc;
            if (w_rel > w_sum) begin
                w_err_set = 1'b1;
                w_new     = '0;
            end else begin
                w_new = w_sum - w_rel;
            end
            if (w_new > CNT_MAX) begin
                w_err_set = 1'b1;
                w_new     = CNT_MAX;
            end
            w_cnt_nxt[r] = CNT_W'(w_new);
            if (flush)
                w_cnt_nxt[r] = '0;
        end
        if (flush)
            w_err_set = 1'b0;
    end

    // Counter and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= w_cnt_nxt[r];
            if (w_err_set)
                r_err <= 1'b1;
        end
    end

    // Registered per-register pending flags; register 0 is never tracked.
    always_comb begin
        busy_o[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++)
            busy_o[r] = (r_cnt[r] != '0);
    end

    assign issue_o = w_issue;
    assign err_o   = r_err;

endmodule
